// File: rtl/rf_write_arbiter.sv
// Sole writer of the register file: arbitrates ALU (A) and load (M) writebacks and runs a zeroing sweep.
// 1-cycle latency from accept to write; M has priority, but A is forced through after STARVE_MAX losses.
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  input  logic              clear_req,
  output logic              busy,
  output logic              write_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [3:0]        starve_q, starve_d;
  logic              write_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              run, force_a;

  // A pending clear blocks both grants so the request survives the sweep untouched.
  assign run     = (state_q == S_RUN) && !clear_req;
  assign force_a = (starve_q == STARVE_LIM);
  assign m_ready = run && m_valid && !force_a;
  assign a_ready = run && a_valid && (!m_valid || force_a);
  assign busy    = (state_q == S_CLEAR);

  always_comb begin
    starve_d = starve_q;
    if (clear_req || !a_valid || a_ready)
      starve_d = '0;
    else if (starve_q != STARVE_LIM)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      starve_q   <= '0;
      write_en_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          write_en_q <= 1'b1;
          wr_addr_q  <= cnt_q;
          wr_data_q  <= '0;
          cnt_q      <= cnt_q + 1'b1;
          starve_q   <= '0;
          if (cnt_q == LAST_ADDR)
            state_q <= S_RUN;
        end
        S_RUN: begin
          starve_q <= starve_d;
          if (clear_req) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            write_en_q <= 1'b0;
          end else if (m_ready) begin
            // Register 0 is hardwired: the grant completes but nothing is written.
            write_en_q <= |m_addr;
            wr_addr_q  <= m_addr;
            wr_data_q  <= m_data;
          end else if (a_ready) begin
            write_en_q <= |a_addr;
            wr_addr_q  <= a_addr;
            wr_data_q  <= a_data;
          end else begin
            write_en_q <= 1'b0;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign write_en = write_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter against a cycle-level behavioural model.
module tb_rf_write_arbiter;
  localparam int DW = 32, AW = 5, SMAX = 4, NREG = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, m_valid, clear_req;
  logic [AW-1:0] a_addr, m_addr;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready, busy, write_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int tests = 0, fails = 0;

  // Model state: sweep flag/position, starvation count, expected write outputs.
  bit            sw;
  int            cnt, starve;
  logic          ew;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;
  bit            exp_ar, exp_mr, dut_ar, dut_mr;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .clear_req(clear_req), .busy(busy),
    .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sw = 1; cnt = 0; starve = 0; ew = 0; ea = '0; ed = '0;
  endtask

  // Called at posedge+1; checks grants mid-cycle, then outputs after the next edge.
  task automatic cycle();
    bit run, force_a, was_sw;
    run     = !sw && !clear_req;
    force_a = (starve == SMAX);
    exp_mr  = run && m_valid && !force_a;
    exp_ar  = run && a_valid && (!m_valid || force_a);
    #1;
    dut_ar = a_ready; dut_mr = m_ready;
    chk("a_ready", {63'd0, a_ready}, {63'd0, exp_ar});
    chk("m_ready", {63'd0, m_ready}, {63'd0, exp_mr});
    chk("busy", {63'd0, busy}, {63'd0, sw});
    @(posedge clk);
    was_sw = sw;
    if (sw) begin
      ew = 1; ea = cnt[AW-1:0]; ed = '0; cnt++;
      if (cnt == NREG) begin sw = 0; cnt = 0; end
    end else if (clear_req) begin
      sw = 1; cnt = 0; ew = 0;
    end else if (exp_mr) begin
      ew = (m_addr != 0); ea = m_addr; ed = m_data;
    end else if (exp_ar) begin
      ew = (a_addr != 0); ea = a_addr; ed = a_data;
    end else begin
      ew = 0;
    end
    if (was_sw || clear_req || !a_valid || exp_ar) starve = 0;
    else starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
    #1;
    chk("write_en", {63'd0, write_en}, {63'd0, ew});
    chk("wr_addr", {59'd0, wr_addr}, {59'd0, ea});
    chk("wr_data", {32'd0, wr_data}, {32'd0, ed});
  endtask

  initial begin
    reset = 1; clear_req = 0;
    a_valid = 0; a_addr = '0; a_data = '0;
    m_valid = 0; m_addr = '0; m_data = '0;
    model_reset();
    #2;
    chk("rst_write_en", {63'd0, write_en}, 64'd0);
    chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_readies", {62'd0, a_ready, m_ready}, 64'd0);
    @(posedge clk); #1 reset = 0;

    // Power-up sweep, then one idle cycle.
    repeat (NREG) cycle();
    chk("sweep_end_addr", {59'd0, wr_addr}, 64'd31);
    chk("sweep_end_busy", {63'd0, busy}, 64'd0);
    cycle();
    chk("idle_we", {63'd0, write_en}, 64'd0);

    // A alone.
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    chk("a_only_ready", {63'd0, dut_ar}, 64'd1);
    chk("a_only_data", {32'd0, wr_data}, 64'hDEADBEEF);
    a_valid = 0;

    // Contention: M wins four times, then A is forced through.
    a_valid = 1; a_addr = 5'd7; a_data = 32'hA0A0A0A0;
    m_valid = 1; m_addr = 5'd1; m_data = 32'h11110000;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("both_ready", {63'd0, dut_ar && dut_mr}, 64'd0);
      chk("grant_a", {63'd0, dut_ar}, {63'd0, (i == 4)});
      chk("grant_m", {63'd0, dut_mr}, {63'd0, (i != 4)});
      if (dut_mr) begin m_addr = m_addr + 1'b1; m_data = m_data + 1; end
      if (dut_ar) a_valid = 0;
    end
    m_valid = 0;

    // Load to register 0 is accepted but not written.
    m_valid = 1; m_addr = 5'd0; m_data = 32'h1234;
    cycle();
    chk("r0_ready", {63'd0, dut_mr}, 64'd1);
    chk("r0_we", {63'd0, write_en}, 64'd0);
    m_valid = 0;

    // Clear collides with a pending A; A waits out the sweep.
    a_valid = 1; a_addr = 5'd9; a_data = 32'h99999999; clear_req = 1;
    cycle();
    chk("clr_a_blocked", {63'd0, dut_ar}, 64'd0);
    clear_req = 0;
    repeat (NREG) cycle();
    cycle();
    chk("post_clr_a_ready", {63'd0, dut_ar}, 64'd1);
    chk("post_clr_addr", {59'd0, wr_addr}, 64'd9);
    a_valid = 0;

    // Reset after ten sweep writes aborts and restarts the sweep.
    clear_req = 1; cycle(); clear_req = 0;
    repeat (10) cycle();
    #2 reset = 1;
    #1;
    chk("mid_rst_we", {63'd0, write_en}, 64'd0);
    chk("mid_rst_addr", {59'd0, wr_addr}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd1);
    model_reset();
    @(posedge clk); #1 reset = 0;
    repeat (NREG) cycle();
    chk("restart_end_addr", {59'd0, wr_addr}, 64'd31);

    // Random traffic with legal handshakes and occasional clears.
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || dut_ar) begin
        a_valid = ($urandom_range(0, 2) != 0); a_addr = AW'($urandom); a_data = DW'($urandom);
      end
      if (!m_valid || dut_mr) begin
        m_valid = ($urandom_range(0, 2) != 0); m_addr = AW'($urandom); m_data = DW'($urandom);
      end
      clear_req = ($urandom_range(0, 59) == 0);
      cycle();
      clear_req = 0;
      chk("rnd_both_ready", {63'd0, dut_ar && dut_mr}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sole driver of the register file write port (write_en, wr_addr, wr_data).
- Shares that port between two writeback requesters: ALU result (A) and memory-load result (M).
- Sequences a 32-cycle zeroing sweep of the register file after reset or on clear_req.
- Sits between the writeback stage and the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width; register count = 2**ADDR_W
STARVE_MAX, 4, consecutive cycles A may lose arbitration before A is forced to win; range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  ALU writeback request
a_addr  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
a_ready  output  1  ALU request accepted this cycle
m_valid  input  1  load writeback request
m_addr  input  ADDR_W  load destination register
m_data  input  DATA_W  load data
m_ready  output  1  load request accepted this cycle
clear_req  input  1  one-cycle pulse requesting a full register-file clear
busy  output  1  high while the clear sweep is running
write_en  output  1  register file write enable (registered)
wr_addr  output  ADDR_W  register file write address (registered)
wr_data  output  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, active-high):
  - State = CLEAR, clear counter = 0, starve counter = 0.
  - write_en = 0, wr_addr = 0, wr_data = 0; busy = 1; a_ready = m_ready = 0.
  - Reset asserted mid-sweep or mid-transfer aborts it immediately; nothing pending survives.
- State CLEAR (busy = 1, a_ready = m_ready = 0):
  - Each rising edge registers write_en = 1, wr_addr = counter, wr_data = 0, then increments counter.
  - After the edge that issues address 2**ADDR_W-1, state = RUN and counter = 0.
  - Sweep is exactly 2**ADDR_W edges (32 at default).
  - clear_req during CLEAR is ignored; it does not restart the sweep.
- State RUN (busy = 0):
  - Grant is combinational from the valids and starve counter.
  - Default priority is M: m_ready = m_valid && !force_a.
  - a_ready = a_valid && (!m_valid || force_a).
  - force_a = (starve counter == STARVE_MAX).
  - At most one ready is high per cycle.
- Starve counter:
  - Increments when a_valid && !a_ready.
  - Clears when a_ready, or when a_valid = 0.
  - Saturates at STARVE_MAX.
- Handshake:
  - Transfer occurs when valid && ready.
  - A requester must hold valid/addr/data stable until ready.
  - Valid must not drop before ready; behaviour if it does is undefined.
- Latency: the accepted request appears on wr_addr/wr_data with write_en = 1 on the next rising edge (1 cycle).
- Idle: with no transfer in a cycle, next edge write_en = 0; wr_addr/wr_data hold their previous values.
- Register 0 writes:
  - A request with addr = 0 is accepted normally (ready high).
  - The resulting write_en = 0, so register 0 is never written in RUN.
  - Such a grant still clears the starve counter if it is A.
- clear_req in RUN:
  - At the next edge, state = CLEAR and counter = 0.
  - In that same cycle both readies are forced to 0, so no new transfer.
  - A write already registered on the outputs completes unaffected.
  - Starve counter cleared.
- Simultaneous clear_req and valid in RUN: clear wins; the request stays pending and is granted after the sweep.

Test Plan:
- Release reset, valids low -> write_en = 1 for 32 consecutive edges, wr_addr 0..31, wr_data = 0, busy = 1; busy = 0 on the cycle after the addr-31 write; write_en = 0 afterwards.
- RUN, a_valid only, a_addr = 5, a_data = 0xDEADBEEF -> a_ready = 1 same cycle; next edge write_en = 1, wr_addr = 5, wr_data = 0xDEADBEEF.
- RUN, m_valid and a_valid held continuously (M addrs 1,2,3,...; A addr 7) -> M granted 4 cycles, A granted on 5th cycle (STARVE_MAX = 4), then M resumes; never both ready in one cycle.
- RUN, m_valid with m_addr = 0, m_data = 0x1234 -> m_ready = 1; next edge write_en = 0.
- RUN, clear_req pulse while a_valid held (a_addr = 9) -> a_ready = 0 that cycle; 32-cycle sweep follows; after the sweep a_ready = 1 and the next edge writes addr 9.
- Assert reset at sweep count 10, release -> outputs zero asynchronously; new sweep restarts from addr 0 and runs the full 32 cycles.
